bf_weight_sched: RTL and testbench
==================================

// Module: bf_weight_sched
// PURPOSE
//  Weight-table controller for the 8-element, 2-beam beamformer/delta-sigma datapath.
//  Stores per-angle cos/sin steering weights written by a host config port.
//  On a steer request, copies one beam's weight set into shadow registers.
//  Commits the shadow set to the live w_cos_*/w_sin_* buses only on a sample-strobe cycle.
//  Also generates that sample strobe (sample_en), so weights never change mid-sample.
// PARAMETERS
//  N_ELEM    8   antenna elements per beam
//  W_WIDTH   5   signed two's-complement weight width
//  N_ANGLES  16  stored steering angles per beam (AW = clog2(N_ANGLES))
//  RATIO     8   clock cycles per sample strobe (>=2)
// PORTS
//  clock        in   1               system clock, all logic on rising edge
//  reset_n      in   1               asynchronous reset, active-low
//  cfg_valid    in   1               host weight write request
//  cfg_ready    out  1               write accepted when cfg_valid&&cfg_ready at edge
//  cfg_beam     in   1               0=beam 1, 1=beam 2
//  cfg_angle    in   AW              angle index
//  cfg_elem     in   clog2(N_ELEM)   element index
//  cfg_cos      in   W_WIDTH         cos weight
//  cfg_sin      in   W_WIDTH         sin weight
//  steer_valid  in   1               steer request
//  steer_ready  out  1               high only in IDLE
//  steer_beam   in   1               beam to re-steer
//  steer_angle  in   AW              angle to load
//  steer_err    out  1               1-cycle pulse: accepted steer had angle >= N_ANGLES
//  busy         out  1               state != IDLE
//  sample_en    out  1               1-cycle sample strobe, period RATIO
//  w_cos_1      out  N_ELEM*W_WIDTH  beam 1 cos weights; element k at [k*W_WIDTH +: W_WIDTH]
//  w_sin_1      out  N_ELEM*W_WIDTH  beam 1 sin weights, same packing
//  w_cos_2      out  N_ELEM*W_WIDTH  beam 2 cos weights, same packing
//  w_sin_2      out  N_ELEM*W_WIDTH  beam 2 sin weights, same packing
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE, strobe counter=0, sample_en=0, steer_err=0.
//   - All w_* outputs = 0; shadow regs = 0; table contents not reset.
//  Strobe: counter runs 0..RATIO-1 and wraps.
//   - sample_en=1 exactly while counter==RATIO-1.
//   - First pulse is the RATIO-th cycle after reset release.
//   - Counter is free-running, independent of the FSM.
//  Table: 2*N_ANGLES*N_ELEM entries of {cos,sin}, single read port.
//   - cfg_ready = (state != COPY).
//   - An accepted write lands at that edge.
//  FSM states: IDLE, COPY, ARMED.
//   - IDLE -> COPY on steer_valid&&steer_ready with angle < N_ANGLES; latch beam/angle.
//   - IDLE with angle >= N_ANGLES: steer accepted, steer_err pulses next cycle, stay IDLE, nothing else changes.
//   - COPY: read element 0..N_ELEM-1, one per cycle, into shadow; takes N_ELEM cycles, then ARMED.
//   - ARMED: at the edge where sample_en==1, copy shadow into the latched beam's w_cos/w_sin, then -> IDLE.
//   - The other beam's outputs are never touched.
//   - A strobe during COPY is ignored; commit waits for the next strobe.
//  Latency: steer accepted at edge t gives ARMED after edge t+N_ELEM; commit at the first strobe edge after that.
//  Simultaneous events:
//   - cfg write and steer accepted at the same IDLE edge: the write is visible to the COPY (write-before-read).
//   - cfg writes during ARMED do not alter the shadow.
//  Arithmetic: none. Weights pass through bit-exact; sign is the caller's encoding.
//  Reset mid-operation: aborts COPY/ARMED, drops the pending steer, outputs return to 0.
// CONFIGURATION
//  BF_WSCHED_UPD_PULSE_EN defined:
//   - Adds output port upd_done (1 bit, reset 0).
//   - upd_done pulses high for the one cycle after each commit edge.
//  BF_WSCHED_UPD_PULSE_EN undefined:
//   - Port upd_done and its logic are absent; all other behaviour is identical.
// TESTING
//  1 Reset, then release reset_n -> all w_* == 0; sample_en high on cycles 8,16,24... (RATIO=8).
//  2 Write beam0 angle3 elem k: cos=k, sin=-k (k=0..7); steer beam0 angle3
//    -> w_cos_1[k]==k, w_sin_1[k]==-k only after a strobe edge;
//    -> unchanged before that edge; w_cos_2/w_sin_2 stay 0.
//  3 Second steer issued while busy -> steer_ready=0 until the cycle after commit;
//    -> the held request is then accepted, and its weights commit on a later strobe.
//  4 cfg_valid asserted during COPY -> cfg_ready=0, write stalls until ARMED;
//    -> the stalled write does not appear in the committed weights.
//  5 N_ANGLES=12 override, steer angle 13 -> steer_err pulses once; busy stays 0; w_* unchanged.
//  6 reset_n pulsed low while ARMED -> w_* == 0 immediately, busy=0;
//    -> no commit occurs at the next strobe; if BF_WSCHED_UPD_PULSE_EN, upd_done stays 0.

Source files
------------

// File: rtl/bf_weight_sched.sv
// Beam weight table plus shadow/commit scheduler. Steer -> ARMED after N_ELEM cycles, commit on the next sample strobe.
// cfg_ready drops during COPY and steer_ready is high only in IDLE. Optional upd_done pulse: BF_WSCHED_UPD_PULSE_EN.
module bf_weight_sched #(
   parameter int N_ELEM   = 8,
   parameter int W_WIDTH  = 5,
   parameter int N_ANGLES = 16,
   parameter int RATIO    = 8,
   localparam int AW = (N_ANGLES > 1) ? $clog2(N_ANGLES) : 1,
   localparam int EW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic                      cfg_beam,
   input  logic [AW-1:0]             cfg_angle,
   input  logic [EW-1:0]             cfg_elem,
   input  logic [W_WIDTH-1:0]        cfg_cos,
   input  logic [W_WIDTH-1:0]        cfg_sin,
   input  logic                      steer_valid,
   output logic                      steer_ready,
   input  logic                      steer_beam,
   input  logic [AW-1:0]             steer_angle,
   output logic                      steer_err,
   output logic                      busy,
   output logic                      sample_en,
`ifdef BF_WSCHED_UPD_PULSE_EN
   output logic                      upd_done,
`endif
   output logic [N_ELEM*W_WIDTH-1:0] w_cos_1,
   output logic [N_ELEM*W_WIDTH-1:0] w_sin_1,
   output logic [N_ELEM*W_WIDTH-1:0] w_cos_2,
   output logic [N_ELEM*W_WIDTH-1:0] w_sin_2
);

   localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_COPY  = 2'd1;
   localparam logic [1:0] S_ARMED = 2'd2;
   localparam logic [AW:0] ANG_LIM = (AW+1)'(N_ANGLES);

   logic [1:0]           state;
   logic [CW-1:0]        strobe_cnt;
   logic [EW-1:0]        elem_cnt;
   logic                 beam_q;
   logic [AW-1:0]        angle_q;
   logic [2*W_WIDTH-1:0] table_mem [2][N_ANGLES][N_ELEM];
   logic [W_WIDTH-1:0]   sh_cos [N_ELEM];
   logic [W_WIDTH-1:0]   sh_sin [N_ELEM];
   logic [2*W_WIDTH-1:0] rd_dat;
   logic                 steer_acc;
   logic                 angle_ok;
   logic                 cfg_wr;
   logic                 commit;

   assign cfg_ready   = (state != S_COPY);
   assign steer_ready = (state == S_IDLE);
   assign busy        = (state != S_IDLE);
   assign sample_en   = (strobe_cnt == CW'(RATIO-1));
   assign steer_acc   = steer_valid && steer_ready;
   assign angle_ok    = ({1'b0, steer_angle} < ANG_LIM);
   assign cfg_wr      = cfg_valid && cfg_ready && ({1'b0, cfg_angle} < ANG_LIM);
   assign commit      = (state == S_ARMED) && sample_en;
   assign rd_dat      = table_mem[beam_q][angle_q][elem_cnt];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         strobe_cnt <= '0;
      else if (sample_en)
         strobe_cnt <= '0;
      else
         strobe_cnt <= strobe_cnt + CW'(1);
   end

   // Table is deliberately left unreset; a same-edge write is seen by a COPY starting at that edge.
   always_ff @(posedge clock) begin
      if (cfg_wr)
         table_mem[cfg_beam][cfg_angle][cfg_elem] <= {cfg_cos, cfg_sin};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         elem_cnt  <= '0;
         beam_q    <= 1'b0;
         angle_q   <= '0;
         steer_err <= 1'b0;
         w_cos_1   <= '0;
         w_sin_1   <= '0;
         w_cos_2   <= '0;
         w_sin_2   <= '0;
         for (int k = 0; k < N_ELEM; k++) begin
            sh_cos[k] <= '0;
            sh_sin[k] <= '0;
         end
      end else begin
         steer_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (steer_acc) begin
                  if (angle_ok) begin
                     state    <= S_COPY;
                     beam_q   <= steer_beam;
                     angle_q  <= steer_angle;
                     elem_cnt <= '0;
                  end else begin
                     steer_err <= 1'b1;
                  end
               end
            end
            S_COPY: begin
               sh_cos[elem_cnt] <= rd_dat[2*W_WIDTH-1:W_WIDTH];
               sh_sin[elem_cnt] <= rd_dat[W_WIDTH-1:0];
               if (elem_cnt == EW'(N_ELEM-1))
                  state <= S_ARMED;
               else
                  elem_cnt <= elem_cnt + EW'(1);
            end
            S_ARMED: begin
               if (commit) begin
                  state <= S_IDLE;
                  for (int k = 0; k < N_ELEM; k++) begin
                     if (beam_q) begin
                        w_cos_2[k*W_WIDTH +: W_WIDTH] <= sh_cos[k];
                        w_sin_2[k*W_WIDTH +: W_WIDTH] <= sh_sin[k];
                     end else begin
                        w_cos_1[k*W_WIDTH +: W_WIDTH] <= sh_cos[k];
                        w_sin_1[k*W_WIDTH +: W_WIDTH] <= sh_sin[k];
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef BF_WSCHED_UPD_PULSE_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         upd_done <= 1'b0;
      else
         upd_done <= commit;
   end
`endif

endmodule

// File: tb/tb_bf_weight_sched.sv
// Scoreboard bench for bf_weight_sched: table/commit model driven by handshakes, monitor checks every cycle.
module tb_bf_weight_sched;
   localparam int N  = 8;
   localparam int W  = 5;
   localparam int NA = 16;
   localparam int R  = 8;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic         cfg_valid = 1'b0, cfg_ready, cfg_beam = 1'b0;
   logic [3:0]   cfg_angle = '0;
   logic [2:0]   cfg_elem = '0;
   logic [W-1:0] cfg_cos = '0, cfg_sin = '0;
   logic         steer_valid = 1'b0, steer_ready, steer_beam = 1'b0;
   logic [3:0]   steer_angle = '0;
   logic         steer_err, busy, sample_en;
   logic [N*W-1:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
   logic         upd_done;

   logic         s12_valid = 1'b0, s12_beam = 1'b0;
   logic [3:0]   s12_angle = '0;
   logic         cfg_ready12, steer_ready12, steer_err12, busy12, sample_en12, upd_done12;
   logic [N*W-1:0] wc1_12, ws1_12, wc2_12, ws2_12;

   bf_weight_sched u_dut (
      .clock(clock), .reset_n(reset_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_beam(cfg_beam),
      .cfg_angle(cfg_angle), .cfg_elem(cfg_elem), .cfg_cos(cfg_cos), .cfg_sin(cfg_sin),
      .steer_valid(steer_valid), .steer_ready(steer_ready), .steer_beam(steer_beam),
      .steer_angle(steer_angle), .steer_err(steer_err), .busy(busy), .sample_en(sample_en),
`ifdef BF_WSCHED_UPD_PULSE_EN
      .upd_done(upd_done),
`endif
      .w_cos_1(w_cos_1), .w_sin_1(w_sin_1), .w_cos_2(w_cos_2), .w_sin_2(w_sin_2)
   );

   bf_weight_sched #(.N_ANGLES(12)) u_dut12 (
      .clock(clock), .reset_n(reset_n),
      .cfg_valid(1'b0), .cfg_ready(cfg_ready12), .cfg_beam(1'b0),
      .cfg_angle(4'd0), .cfg_elem(3'd0), .cfg_cos(5'd0), .cfg_sin(5'd0),
      .steer_valid(s12_valid), .steer_ready(steer_ready12), .steer_beam(s12_beam),
      .steer_angle(s12_angle), .steer_err(steer_err12), .busy(busy12), .sample_en(sample_en12),
`ifdef BF_WSCHED_UPD_PULSE_EN
      .upd_done(upd_done12),
`endif
      .w_cos_1(wc1_12), .w_sin_1(ws1_12), .w_cos_2(wc2_12), .w_sin_2(ws2_12)
   );

`ifndef BF_WSCHED_UPD_PULSE_EN
   assign upd_done   = 1'b0;
   assign upd_done12 = 1'b0;
`endif

   typedef struct {
      logic           beam;
      logic [N*W-1:0] cos;
      logic [N*W-1:0] sin;
      int             t;
      int             e;
   } exp_t;

   exp_t           sb_q[$];
   logic [W-1:0]   m_cos [2][NA][N];
   logic [W-1:0]   m_sin [2][NA][N];
   logic [N*W-1:0] live_cos [2];
   logic [N*W-1:0] live_sin [2];
   int tests = 0;
   int fails = 0;
   int edge_cnt = 0;

   always @(posedge clock) begin
      if (!reset_n) edge_cnt = 0;
      else          edge_cnt = edge_cnt + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @edge %0d: got %h expected %h", name, edge_cnt, act, exp);
      end
   endtask

   // Snapshot of the selected table row; commit lands on the first strobe edge once ARMED.
   function automatic exp_t make_exp(input logic b, input logic [3:0] a, input int t);
      exp_t x;
      x.beam = b;
      for (int k = 0; k < N; k++) begin
         x.cos[k*W +: W] = m_cos[b][a][k];
         x.sin[k*W +: W] = m_sin[b][a][k];
      end
      x.t = t;
      x.e = ((t + N + 1 + R - 1) / R) * R;
      return x;
   endfunction

   task automatic do_op(input bit dc, input logic cb, input logic [3:0] ca, input logic [2:0] ce,
                        input logic [W-1:0] cc, input logic [W-1:0] cs,
                        input bit ds, input logic sbm, input logic [3:0] sa);
      bit cp, sp, cr, sr;
      cp = dc; sp = ds;
      cfg_valid = dc; cfg_beam = cb; cfg_angle = ca; cfg_elem = ce; cfg_cos = cc; cfg_sin = cs;
      steer_valid = ds; steer_beam = sbm; steer_angle = sa;
      for (int i = 0; i < 200 && (cp || sp); i++) begin
         cr = cfg_ready;
         sr = steer_ready;
         @(negedge clock);
         if (cp && cr) begin
            m_cos[cb][ca][ce] = cc;
            m_sin[cb][ca][ce] = cs;
            cp = 0;
            cfg_valid = 1'b0;
         end
         if (sp && sr) begin
            sb_q.push_back(make_exp(sbm, sa, edge_cnt));
            sp = 0;
            steer_valid = 1'b0;
         end
      end
      if (cp || sp) begin
         tests++; fails++;
         $display("FAIL handshake_timeout: cfg pending %0d steer pending %0d", cp, sp);
         cfg_valid = 1'b0;
         steer_valid = 1'b0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge clock);
      if (sb_q.size() > 0) begin
         tests++; fails++;
         $display("FAIL drain_timeout: %0d commits outstanding, required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   // Monitor: compares every cycle against the model; a busy fall is the DUT presenting a commit.
   initial begin
      int k;
      bit pend, busy_e, copy_e, committed, prev_busy;
      exp_t x;
      prev_busy = 0;
      forever begin
         @(negedge clock);
         #1;
         if (!reset_n) begin
            prev_busy = 0;
            continue;
         end
         k = edge_cnt;
         pend = (sb_q.size() > 0);
         busy_e = pend && k >= sb_q[0].t && k < sb_q[0].e;
         copy_e = pend && k >= sb_q[0].t && k < sb_q[0].t + N;
         chk("sample_en", sample_en, ((k % R) == R - 1));
         chk("busy", busy, busy_e);
         chk("steer_ready", steer_ready, !busy_e);
         chk("cfg_ready", cfg_ready, !copy_e);
         chk("steer_err", steer_err, 1'b0);
         committed = 0;
         if (prev_busy && !busy) begin
            if (!pend) begin
               tests++; fails++;
               $display("FAIL commit_spurious @edge %0d: commit seen, none expected", k);
            end else begin
               x = sb_q.pop_front();
               chk("commit_edge", k, x.e);
               live_cos[x.beam] = x.cos;
               live_sin[x.beam] = x.sin;
               committed = 1;
            end
         end else if (pend && k >= sb_q[0].e) begin
            tests++; fails++;
            $display("FAIL commit_missing @edge %0d: expected commit at edge %0d", k, sb_q[0].e);
            x = sb_q.pop_front();
         end
         prev_busy = busy;
         chk("w_cos_1", w_cos_1, live_cos[0]);
         chk("w_sin_1", w_sin_1, live_sin[0]);
         chk("w_cos_2", w_cos_2, live_cos[1]);
         chk("w_sin_2", w_sin_2, live_sin[1]);
`ifdef BF_WSCHED_UPD_PULSE_EN
         chk("upd_done", upd_done, committed);
`endif
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] v;
      live_cos[0] = '0; live_sin[0] = '0; live_cos[1] = '0; live_sin[1] = '0;

      // Reset state
      repeat (3) @(negedge clock);
      chk("rst_w_cos_1", w_cos_1, '0);
      chk("rst_w_sin_2", w_sin_2, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_sample_en", sample_en, 1'b0);
      chk("rst_steer_err", steer_err, 1'b0);
      chk("rst_upd_done", upd_done, 1'b0);
      reset_n = 1'b1;

      // Fill the whole table with random weights
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < NA; a++)
            for (int e = 0; e < N; e++)
               do_op(1, 1'(b), 4'(a), 3'(e), 5'($urandom), 5'($urandom), 0, 1'b0, 4'd0);

      // Beam 1 angle 3: cos=k, sin=-k
      for (int e = 0; e < N; e++) begin
         v = W'(-e);
         do_op(1, 1'b0, 4'd3, 3'(e), 5'(e), v, 0, 1'b0, 4'd0);
      end
      do_op(0, 1'b0, 4'd0, 3'd0, 5'd0, 5'd0, 1, 1'b0, 4'd3);
      drain();

      // Back-to-back steers: the second is held until the first commits
      do_op(0, 1'b0, 4'd0, 3'd0, 5'd0, 5'd0, 1, 1'b1, 4'd5);
      do_op(0, 1'b0, 4'd0, 3'd0, 5'd0, 5'd0, 1, 1'b0, 4'd7);
      drain();

      // Write during COPY stalls and is excluded; a later steer picks it up
      do_op(0, 1'b0, 4'd0, 3'd0, 5'd0, 5'd0, 1, 1'b1, 4'd2);
      do_op(1, 1'b1, 4'd2, 3'd0, 5'h15, 5'h0a, 0, 1'b0, 4'd0);
      drain();
      do_op(0, 1'b0, 4'd0, 3'd0, 5'd0, 5'd0, 1, 1'b1, 4'd2);
      drain();

      // Same-edge write and steer: write is visible to the copy
      do_op(1, 1'b0, 4'd9, 3'd4, 5'h11, 5'h0f, 1, 1'b0, 4'd9);
      drain();

      // Out-of-range angle on the 12-angle instance
      s12_valid = 1'b1; s12_beam = 1'b0; s12_angle = 4'd13;
      chk("d12_steer_ready", steer_ready12, 1'b1);
      @(negedge clock);
      s12_valid = 1'b0;
      chk("d12_steer_err_pulse", steer_err12, 1'b1);
      chk("d12_busy", busy12, 1'b0);
      @(negedge clock);
      chk("d12_steer_err_clear", steer_err12, 1'b0);
      chk("d12_busy_after", busy12, 1'b0);
      chk("d12_w", {wc1_12, ws1_12} | {wc2_12, ws2_12}, '0);
      chk("d12_upd_done", upd_done12, 1'b0);

      // Reset while ARMED
      for (int i = 0; i < 2 * R && (edge_cnt % R) != 0; i++) @(negedge clock);
      do_op(0, 1'b0, 4'd0, 3'd0, 5'd0, 5'd0, 1, 1'b1, 4'd11);
      repeat (N) @(negedge clock);
      chk("armed_busy", busy, 1'b1);
      reset_n = 1'b0;
      sb_q.delete();
      live_cos[0] = '0; live_sin[0] = '0; live_cos[1] = '0; live_sin[1] = '0;
      #1;
      chk("midrst_w_cos_1", w_cos_1, '0);
      chk("midrst_w_sin_1", w_sin_1, '0);
      chk("midrst_w_cos_2", w_cos_2, '0);
      chk("midrst_w_sin_2", w_sin_2, '0);
      chk("midrst_busy", busy, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3 * R) @(negedge clock);

      // Randomized mix of writes, steers, concurrent write+steer and idle gaps
      for (int it = 0; it < 40; it++) begin
         logic [3:0] a;
         logic       b;
         a = 4'($urandom);
         b = 1'($urandom);
         case ($urandom_range(0, 3))
            0: do_op(1, b, a, 3'($urandom), 5'($urandom), 5'($urandom), 0, 1'b0, 4'd0);
            1: do_op(0, 1'b0, 4'd0, 3'd0, 5'd0, 5'd0, 1, b, a);
            2: do_op(1, b, a, 3'($urandom), 5'($urandom), 5'($urandom), 1, b, a);
            default: repeat ($urandom_range(0, 10)) @(negedge clock);
         endcase
      end
      drain();
      repeat (4) @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
